// File: rtl/note_scorer_pkg.sv
// note_scorer_pkg: shared types, limits and BCD helpers for the note scorer.
//   lane_state_e  : per-lane judging state (EMPTY / PENDING / SPENT)
//   BCD_MAX       : saturated 4-digit BCD score
//   CNT_MAX       : saturated 8-bit counter value
//   BONUS_COMBO   : combo length from which hits are worth double
//                   (used only when SCORE_COMBO_BONUS_EN is defined)
package note_scorer_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PENDING = 2'd1,
    SPENT   = 2'd2
  } lane_state_e;

  localparam logic [15:0] BCD_MAX     = 16'h9999;
  localparam logic [7:0]  CNT_MAX     = 8'd255;
  localparam int          BONUS_COMBO = 10;

  // Adds a small binary value (0..8) to a 4-digit BCD number and saturates
  // at 9999. The increment enters as the carry into the lowest digit, so each
  // digit sees at most 9 + 8 = 17 and a single -10 correction is enough.
  function automatic logic [15:0] bcd_add_sat(input logic [15:0] a,
                                              input logic [3:0]  b);
    logic [15:0] r;
    logic [4:0]  d;
    logic [3:0]  c;
    r = '0;
    c = b;
    for (int i = 0; i < 4; i++) begin
      d = {1'b0, a[4*i +: 4]} + {1'b0, c};
      if (d > 5'd9) begin
        d = d - 5'd10;
        c = 4'd1;
      end else begin
        c = 4'd0;
      end
      r[4*i +: 4] = d[3:0];
    end
    return (c != 4'd0) ? BCD_MAX : r;
  endfunction

  // 8-bit saturating add of a small increment.
  function automatic logic [7:0] sat8_add(input logic [7:0] a,
                                          input logic [2:0] n);
    logic [8:0] s;
    s = {1'b0, a} + {6'd0, n};
    return s[8] ? CNT_MAX : s[7:0];
  endfunction

endpackage

// File: rtl/note_scorer_debounce.sv
// button_debounce: conditions one raw push-button.
//   clk_i   : system clock
//   rst_i   : asynchronous active-low reset
//   btn_i   : raw asynchronous button, active-high
//   press_o : one-cycle pulse on the rising edge of the accepted level
// Path: 2-FF synchronizer -> stability counter -> rising-edge pulse.
// The accepted level flips only after DEBOUNCE_CYCLES consecutive samples
// that all differ from it. The synchronizer resets to "pressed" and press
// pulses stay disarmed until the button is seen released, so a button held
// through reset release never produces a press.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0]    sync_q;
  logic          level_q;
  logic          armed_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync_q  <= 2'b11;
      level_q <= 1'b0;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      press_o <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      armed_q <= armed_q | ~sync_q[1];
      press_o <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt_q   <= '0;
        level_q <= sync_q[1];
        press_o <= sync_q[1] & armed_q;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/note_scorer.sv
// note_scorer: judges button presses against the hit-zone slice of each
// lane's falling note line and keeps the score, combo and miss counters.
//   clk_i        : system clock
//   rst_i        : asynchronous active-low reset
//   en_i         : judging enable (low = paused: lane FSMs and counters hold,
//                  presses are discarded, debouncers keep running)
//   lane_zone_i  : hit-window bits, lane n at [n*ZONE_W +: ZONE_W]
//   btn_i        : raw buttons, active-high, one per lane
//   hit_o/miss_o : registered one-cycle per-lane strobes
//   score_o      : 4-digit BCD score, saturates at 9999
//   combo_o      : consecutive hits, saturates at 255, cleared by any miss
//   misses_o     : total misses, saturates at 255
//   state_o      : lane FSM states, lane n at [2n +: 2] (lane_state_e)
// Optional feature macro SCORE_COMBO_BONUS_EN: hits score 2 points while
// combo_o >= BONUS_COMBO at the start of the cycle.
// LANES is limited to 4 by the per-cycle BCD increment (at most 8 points).
module note_scorer
  import note_scorer_pkg::*;
#(
  parameter int LANES           = 4,
  parameter int ZONE_W          = 18,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic [LANES*ZONE_W-1:0] lane_zone_i,
  input  logic [LANES-1:0]        btn_i,
  output logic [LANES-1:0]        hit_o,
  output logic [LANES-1:0]        miss_o,
  output logic [15:0]             score_o,
  output logic [7:0]              combo_o,
  output logic [7:0]              misses_o,
  output logic [2*LANES-1:0]      state_o
);

  logic [LANES-1:0] press;
  logic [LANES-1:0] present;
  logic [LANES-1:0] hit_c;
  logic [LANES-1:0] miss_c;
  lane_state_e      state_q [LANES];
  lane_state_e      state_d [LANES];
  logic [2:0]       n_hit;
  logic [2:0]       n_miss;
  logic [3:0]       points;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .btn_i  (btn_i[g]),
      .press_o(press[g])
    );
    assign present[g]       = |lane_zone_i[g*ZONE_W +: ZONE_W];
    assign state_o[2*g +: 2] = state_q[g];
  end

  // Lane judging. In PENDING a press wins over the note leaving the zone.
  // In SPENT a press is a stray miss; the lane only re-arms once the zone is
  // clear, so a note following without a gap is never judged on its own.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      state_d[l] = state_q[l];
      hit_c[l]   = 1'b0;
      miss_c[l]  = 1'b0;
      if (en_i) begin
        case (state_q[l])
          EMPTY: begin
            if (press[l]) begin
              hit_c[l]  = present[l];
              miss_c[l] = ~present[l];
              if (present[l]) state_d[l] = SPENT;
            end else if (present[l]) begin
              state_d[l] = PENDING;
            end
          end
          PENDING: begin
            if (press[l]) begin
              hit_c[l]   = 1'b1;
              state_d[l] = SPENT;
            end else if (!present[l]) begin
              miss_c[l]  = 1'b1;
              state_d[l] = EMPTY;
            end
          end
          SPENT: begin
            miss_c[l] = press[l];
            if (!present[l]) state_d[l] = EMPTY;
          end
          default: state_d[l] = EMPTY;
        endcase
      end
    end
  end

  always_comb begin
    n_hit  = '0;
    n_miss = '0;
    for (int l = 0; l < LANES; l++) begin
      n_hit  = n_hit + 3'(hit_c[l]);
      n_miss = n_miss + 3'(miss_c[l]);
    end
  end

`ifdef SCORE_COMBO_BONUS_EN
  assign points = (combo_o >= 8'(BONUS_COMBO)) ? {n_hit, 1'b0} : {1'b0, n_hit};
`else
  assign points = {1'b0, n_hit};
`endif

  // Counters move only with hit/miss activity, which is already suppressed
  // while paused, so no separate enable gating is needed here.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int l = 0; l < LANES; l++) state_q[l] <= EMPTY;
      hit_o    <= '0;
      miss_o   <= '0;
      score_o  <= '0;
      combo_o  <= '0;
      misses_o <= '0;
    end else begin
      for (int l = 0; l < LANES; l++) state_q[l] <= state_d[l];
      hit_o    <= hit_c;
      miss_o   <= miss_c;
      score_o  <= bcd_add_sat(score_o, points);
      combo_o  <= (n_miss != 3'd0) ? 8'd0 : sat8_add(combo_o, n_hit);
      misses_o <= sat8_add(misses_o, n_miss);
    end
  end

endmodule
